// File: rtl/core_pkg.sv
// Shared definitions for the instruction fetch path: default widths and
// the fetch arbiter state encoding.
package core_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant. The priority pointer only moves when the
// granted transaction completes, so it can be reused by any single-outstanding port.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);
  logic r_prio;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_prio <= 1'b0;
    else if (upd_i) r_prio <= ~upd_idx_i;
  end

  assign gnt_vld_o = |req_i;
  assign gnt_idx_o = (&req_i) ? r_prio : req_i[1];
endmodule

// File: rtl/inst_fetch_arbiter.sv
// Shares one instruction memory port between the way0/way1 fetch units with
// round-robin arbitration, one outstanding transaction, and flush-driven drain.
module inst_fetch_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              way0_request_i,
  input  logic [ADDR_W-1:0] way0_instAddr_i,
  input  logic              way0_flush_i,
  output logic [INST_W-1:0] way0_inst_o,
  output logic              way0_dataOk_o,
  input  logic              way1_request_i,
  input  logic [ADDR_W-1:0] way1_instAddr_i,
  input  logic              way1_flush_i,
  output logic [INST_W-1:0] way1_inst_o,
  output logic              way1_dataOk_o,
  output logic              mem_request_o,
  output logic [ADDR_W-1:0] mem_instAddr_o,
  input  logic [INST_W-1:0] mem_inst_i,
  input  logic              mem_dataOk_i,
  output logic              busy_o,
  output logic              owner_o
);
  fetch_state_e      r_state;
  logic              r_owner;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_addr;

  logic w_gnt_vld, w_gnt_idx, w_owner_flush, w_upd, w_ok;

  assign w_owner_flush = r_owner ? way1_flush_i : way0_flush_i;
  // Any response while a transaction is outstanding retires it, delivered or not.
  assign w_upd = (r_state != IDLE) && mem_dataOk_i;
  assign w_ok  = (r_state == BUSY) && mem_dataOk_i && !w_owner_flush;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     ({way1_request_i, way0_request_i}),
    .upd_i     (w_upd),
    .upd_idx_i (r_owner),
    .gnt_vld_o (w_gnt_vld),
    .gnt_idx_o (w_gnt_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_mem_req <= 1'b0;
      r_addr    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_vld) begin
          r_state   <= BUSY;
          r_owner   <= w_gnt_idx;
          r_addr    <= w_gnt_idx ? way1_instAddr_i : way0_instAddr_i;
          r_mem_req <= 1'b1;
        end
        BUSY: if (mem_dataOk_i) begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end else if (w_owner_flush) begin
          // Memory cannot abort; keep requesting and swallow the response.
          r_state <= DRAIN;
        end
        DRAIN: if (mem_dataOk_i) begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign way0_dataOk_o  = w_ok && !r_owner;
  assign way1_dataOk_o  = w_ok &&  r_owner;
  assign way0_inst_o    = r_owner ? '0 : mem_inst_i;
  assign way1_inst_o    = r_owner ? mem_inst_i : '0;
  assign mem_request_o  = r_mem_req;
  assign mem_instAddr_o = r_addr;
  assign busy_o         = (r_state != IDLE);
  assign owner_o        = r_owner;
endmodule
